dmem_port_arbiter: RTL

// - Shares the single data-memory port between the CPU MEM stage and a debug/loader requester.
// - Sits between the cpu MEM-stage signals and datamem.
// - CPU has priority; a starvation counter bounds debug wait.
// - Debug may lock the port for bursts (preload/dump of test data).
// - Losing CPU request raises cpu_stall so the pipeline freezes MEM and older stages.

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_port_arbiter_if.sv | 47 ++++
 rtl/dmem_port_arbiter_starve_ctr.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SIZE_W = 4;

    localparam logic [SIZE_W-1:0] MEM_SIZE_DW = 4'd8;

    typedef enum logic {
        S_CPU,
        S_DBG_LOCK
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
    } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, debug and datamem signals around the port arbiter.
interface dmem_port_arbiter_if;
    import dmem_arb_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [SIZE_W-1:0] cpu_size;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [SIZE_W-1:0] dbg_size;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] MEM_Address;
    logic              MemWrite;
    logic              MemRead;
    logic [SIZE_W-1:0] mem_xfer_size;
    logic [DATA_W-1:0] MEM_Write_Data;
    logic [DATA_W-1:0] MEM_Read_Data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        output cpu_stall, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size, dbg_lock,
        output dbg_gnt, dbg_rdata,
        output MEM_Address, MemWrite, MemRead, mem_xfer_size, MEM_Write_Data,
        input  MEM_Read_Data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        input  cpu_stall, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size, dbg_lock,
        input  dbg_gnt, dbg_rdata,
        input  MEM_Address, MemWrite, MemRead, mem_xfer_size, MEM_Write_Data,
        output MEM_Read_Data
    );

endinterface

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating count of cycles the debug requester has been denied.
module dmem_arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CW'(MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// CPU-priority arbiter for the shared data-memory port with debug lock bursts.
// Optional DMEM_ARB_STATS_EN adds saturating stall/grant counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_cpu_stalls,
    output logic [31:0]         stat_dbg_grants
`endif
);

    localparam int unsigned LW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

    arb_state_t    arb_state_q, arb_state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [LW-1:0] lock_cnt_inc;
    logic          cpu_gnt;
    logic          dbg_gnt;
    logic          wait_at_max;
    logic          wait_clr;
    logic          wait_inc;
    logic          cpu_stall;
    mem_req_t      cpu_rq;
    mem_req_t      dbg_rq;
    mem_req_t      sel_rq;

    assign cpu_rq = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata, size: bus.cpu_size};
    assign dbg_rq = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata, size: bus.dbg_size};

    assign lock_cnt_inc = lock_cnt_q + LW'(1);

    // Grants come straight from registered state and live requests.
    always_comb begin
        arb_state_d = arb_state_q;
        lock_cnt_d  = lock_cnt_q;
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        if (!reset) begin
            unique case (arb_state_q)
                S_CPU: begin
                    if (bus.dbg_req && (!bus.cpu_req || wait_at_max)) begin
                        dbg_gnt = 1'b1;
                    end else if (bus.cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                    if (dbg_gnt && bus.dbg_lock && (LOCK_MAX > 1)) begin
                        arb_state_d = S_DBG_LOCK;
                        lock_cnt_d  = LW'(1);
                    end
                end
                S_DBG_LOCK: begin
                    if (bus.dbg_req && bus.dbg_lock) begin
                        dbg_gnt    = 1'b1;
                        lock_cnt_d = lock_cnt_inc;
                        if (lock_cnt_inc == LW'(LOCK_MAX)) begin
                            arb_state_d = S_CPU;
                            lock_cnt_d  = '0;
                        end
                    end else begin
                        // Releasing the lock hands the same cycle to the CPU.
                        cpu_gnt     = bus.cpu_req;
                        arb_state_d = S_CPU;
                        lock_cnt_d  = '0;
                    end
                end
                default: begin
                    arb_state_d = S_CPU;
                    lock_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_state_q <= S_CPU;
            lock_cnt_q  <= '0;
        end else begin
            arb_state_q <= arb_state_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    // Wait count is meaningless inside a burst, so it is held at zero there.
    assign wait_clr = ~bus.dbg_req | dbg_gnt | (arb_state_q == S_DBG_LOCK);
    assign wait_inc = bus.dbg_req & ~dbg_gnt;

    dmem_arb_starve_ctr #(
        .MAX (MAX_WAIT)
    ) u_starve_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .at_max (wait_at_max)
    );

    assign cpu_stall = bus.cpu_req & ~cpu_gnt & ~reset;

    always_comb begin
        sel_rq = '0;
        if (dbg_gnt) begin
            sel_rq = dbg_rq;
        end else if (cpu_gnt) begin
            sel_rq = cpu_rq;
        end
    end

    assign bus.MemRead        = (cpu_gnt | dbg_gnt) & ~sel_rq.we;
    assign bus.MemWrite       = (cpu_gnt | dbg_gnt) & sel_rq.we;
    assign bus.MEM_Address    = sel_rq.addr;
    assign bus.MEM_Write_Data = sel_rq.wdata;
    assign bus.mem_xfer_size  = sel_rq.size;

    assign bus.cpu_stall = cpu_stall;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.cpu_rdata = cpu_gnt ? bus.MEM_Read_Data : '0;
    assign bus.dbg_rdata = dbg_gnt ? bus.MEM_Read_Data : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] grant_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            if (cpu_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (dbg_gnt && (grant_cnt_q != '1)) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end
        end
    end

    assign stat_cpu_stalls = stall_cnt_q;
    assign stat_dbg_grants = grant_cnt_q;
`endif

endmodule
